// File: rtl/sram_bloom_pkg.sv
// Shared definitions for the Bloom-filter SRAM client: command opcodes,
// FSM states and default SRAM geometry.
package sram_bloom_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH_DEF = 19;
  localparam int unsigned SRAM_DATA_WIDTH_DEF = 36;

  typedef enum logic [1:0] {
    OP_TEST  = 2'd0,
    OP_SET   = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } state_e;

  // The reserved opcode behaves as a TEST.
  function automatic op_e decode_op(logic [1:0] raw);
    case (raw)
      2'd1:    return OP_SET;
      2'd2:    return OP_CLEAR;
      default: return OP_TEST;
    endcase
  endfunction

endpackage

// File: rtl/sram_bloom_client_sat.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/sram_bloom_client.sv
// Requester engine for one arbiter rd/wr port pair: performs Bloom-filter
// TEST / SET (read-modify-write) / CLEAR on one SRAM bucket word at a time.
module sram_bloom_client
  import sram_bloom_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEF,
  parameter int unsigned SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DEF,
  parameter int unsigned RD_TIMEOUT      = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [SRAM_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] cmd_mask,
  output logic                       result_vld,
  output logic                       result_hit,
  output logic                       result_err,
  output logic                       rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       rd_ack,
  input  logic                       rd_vld,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_data,
  output logic                       wr_req,
  output logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_data,
  input  logic                       wr_ack,
  output logic [31:0]                set_count,
  output logic [31:0]                hit_count
);

  localparam int unsigned TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT);

  state_e                     state_q;
  op_e                        op_q;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic [SRAM_DATA_WIDTH-1:0] mask_q;
  logic [SRAM_DATA_WIDTH-1:0] wr_data_q;
  logic [TW-1:0]              tmo_q;
  logic                       hit_q;
  logic                       result_vld_q, result_hit_q, result_err_q;
  logic                       rd_hit;
  logic                       set_inc, hit_inc;

  assign rd_hit = (rd_data & mask_q) == mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_TEST;
      addr_q       <= '0;
      mask_q       <= '0;
      wr_data_q    <= '0;
      tmo_q        <= '0;
      hit_q        <= 1'b0;
      result_vld_q <= 1'b0;
      result_hit_q <= 1'b0;
      result_err_q <= 1'b0;
    end else begin
      result_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q   <= decode_op(cmd_op);
            addr_q <= cmd_addr;
            mask_q <= cmd_mask;
            hit_q  <= 1'b0;
            if (decode_op(cmd_op) == OP_CLEAR) begin
              wr_data_q <= '0;
              state_q   <= ST_WR_REQ;
            end else begin
              state_q <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          if (rd_ack) begin
            tmo_q   <= '0;
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // Result regs are loaded on the transition into DONE so that
          // result_vld and the matching hit/err appear in the same cycle.
          if (rd_vld) begin
            hit_q <= rd_hit;
            if (op_q == OP_SET) begin
              wr_data_q <= rd_data | mask_q;
              state_q   <= ST_WR_REQ;
            end else begin
              result_vld_q <= 1'b1;
              result_hit_q <= rd_hit;
              result_err_q <= 1'b0;
              state_q      <= ST_DONE;
            end
          end else if (tmo_q == TMO_LAST) begin
            result_vld_q <= 1'b1;
            result_hit_q <= 1'b0;
            result_err_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_WR_REQ: begin
          if (wr_ack) begin
            result_vld_q <= 1'b1;
            result_hit_q <= hit_q;
            result_err_q <= 1'b0;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = reset_n && enable && (state_q == ST_IDLE);
  assign rd_req     = (state_q == ST_RD_REQ) && !rd_ack;
  assign wr_req     = (state_q == ST_WR_REQ) && !wr_ack;
  assign rd_addr    = addr_q;
  assign wr_addr    = addr_q;
  assign wr_data    = wr_data_q;
  assign result_vld = result_vld_q;
  assign result_hit = result_hit_q;
  assign result_err = result_err_q;

  assign set_inc = result_vld_q && (op_q == OP_SET) && !result_err_q;
  assign hit_inc = result_vld_q && result_hit_q;

  sat_counter32 u_set_cnt (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .inc_i   (set_inc),
    .count_o (set_count)
  );

  sat_counter32 u_hit_cnt (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .inc_i   (hit_inc),
    .count_o (hit_count)
  );

endmodule

// File: tb/tb_sram_bloom_client.sv
// Bench for sram_bloom_client: plays the SRAM arbiter and compares each
// command's outcome with a memory-array model of the Bloom bit array.
module tb_sram_bloom_client;

  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 36;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          reset_n, enable, cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr, rd_addr, wr_addr;
  logic [DW-1:0] cmd_mask, rd_data, wr_data;
  logic          result_vld, result_hit, result_err;
  logic          rd_req, rd_ack, rd_vld, wr_req, wr_ack;
  logic [31:0]   set_count, hit_count;

  sram_bloom_client #(
    .SRAM_ADDR_WIDTH (AW),
    .SRAM_DATA_WIDTH (DW),
    .RD_TIMEOUT      (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_mask   (cmd_mask),
    .result_vld (result_vld),
    .result_hit (result_hit),
    .result_err (result_err),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_vld     (rd_vld),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .set_count  (set_count),
    .hit_count  (hit_count)
  );

  always #5 clk = ~clk;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [31:0]   set_exp = '0;
  logic [31:0]   hit_exp = '0;
  logic [DW-1:0] last_wd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic touch(input logic [AW-1:0] a);
    if (!mem.exists(a)) mem[a] = rand_word();
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_cmd_ready"}, cmd_ready, 1'b0);
    check({pfx, "_result_vld"}, result_vld, 1'b0);
    check({pfx, "_result_hit"}, result_hit, 1'b0);
    check({pfx, "_result_err"}, result_err, 1'b0);
    check({pfx, "_rd_req"}, rd_req, 1'b0);
    check({pfx, "_wr_req"}, wr_req, 1'b0);
    check({pfx, "_addr_data"}, {rd_addr, wr_addr, wr_data}, '0);
    check({pfx, "_counts"}, {set_count, hit_count}, '0);
  endtask

  // Runs one command end to end, acting as the arbiter; called and
  // returning at about 2-3 time units after a rising edge.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] mask, input int unsigned ack_dly,
                         input int unsigned vld_dly, input bit give_vld,
                         input int unsigned wack_dly, input bit drop_en);
    logic [DW-1:0] old, wd, exp_wd;
    logic [AW-1:0] wa;
    logic          hit_o, err_o;
    bit            is_rd, is_set, is_clr, exp_err, exp_hit, exp_wr;
    bit            got, acked, vpend, wacked;
    int unsigned   rd_seen, wr_seen, rd_gr, wr_gr, bad, cyc, ack_cyc, res_cyc, vcnt;
    got = 0; acked = 0; vpend = 0; wacked = 0;
    rd_seen = 0; wr_seen = 0; rd_gr = 0; wr_gr = 0; bad = 0;
    ack_cyc = 0; res_cyc = 0; vcnt = 0;
    wd = '0; wa = '0; hit_o = 1'bx; err_o = 1'bx;
    is_clr = (op == 2'd2);
    is_set = (op == 2'd1);
    is_rd  = !is_clr;
    touch(addr);
    old = mem[addr];

    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_mask = mask;

    for (cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; rd_ack = 1'b0; rd_vld = 1'b0; wr_ack = 1'b0;
      rd_data = rand_word();
      if (drop_en && cyc == 1) enable = 1'b0;
      #1;
      if (result_vld) begin
        got = 1; hit_o = result_hit; err_o = result_err; res_cyc = cyc;
        break;
      end
      if (rd_req) begin
        if (acked) bad++;
        if (rd_addr !== addr) bad++;
        rd_seen++;
        if (!acked && rd_seen > ack_dly) begin
          rd_ack = 1'b1; acked = 1; rd_gr++; ack_cyc = cyc;
          vcnt = vld_dly; vpend = give_vld;
        end
      end else if (vpend) begin
        vcnt--;
        if (vcnt == 0) begin
          rd_vld = 1'b1; rd_data = old; vpend = 0;
        end
      end
      if (wr_req) begin
        if (wacked) bad++;
        if (wr_addr !== addr) bad++;
        wr_seen++;
        if (!wacked && wr_seen > wack_dly) begin
          wr_ack = 1'b1; wacked = 1; wr_gr++; wd = wr_data; wa = wr_addr;
        end
      end
      #1;
      if ((rd_ack && rd_req) || (wr_ack && wr_req)) bad++;
    end

    exp_err = is_rd && !give_vld;
    exp_hit = is_rd && !exp_err && ((old & mask) == mask);
    exp_wr  = is_clr || (is_set && !exp_err);
    exp_wd  = is_clr ? '0 : (old | mask);
    check("result_vld", got, 1'b1);
    check("result_hit", hit_o, exp_hit);
    check("result_err", err_o, exp_err);
    check("rd_access", rd_gr, is_rd ? 1 : 0);
    check("wr_access", wr_gr, exp_wr ? 1 : 0);
    check("protocol", bad, 0);
    if (exp_wr) begin
      check("wr_addr", wa, addr);
      check("wr_data", wd, exp_wd);
      mem[addr] = exp_wd;
    end
    if (exp_err) check("tmo_latency", res_cyc - (ack_cyc + 1), TMO + 1);
    last_wd = wd;
    if (is_set && !exp_err && set_exp != '1) set_exp++;
    if (exp_hit && hit_exp != '1) hit_exp++;

    @(posedge clk); #2;
    check("vld_pulse", result_vld, 1'b0);
    check("set_count", set_count, set_exp);
    check("hit_count", hit_count, hit_exp);
    enable = 1'b1;
    #1;
    check("ready_after", cmd_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pool [4];
    logic [AW-1:0] a;
    logic [DW-1:0] m;
    int unsigned   bad;

    reset_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
    cmd_addr = '0; cmd_mask = '0; rd_ack = 1'b0; rd_vld = 1'b0;
    rd_data = '0; wr_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outs("rst");
    reset_n = 1'b1;
    @(posedge clk); #2;

    // SET on a word holding 0x4 with mask 0x3
    mem[19'h00010] = 36'h4;
    run_cmd(2'd1, 19'h00010, 36'h3, 1, 3, 1'b1, 0, 1'b0);
    check("t1_wdata", last_wd, 36'h7);
    check("t1_setcnt", set_count, 32'd1);

    // TEST hits against 0x7
    run_cmd(2'd0, 19'h00010, 36'h5, 0, 3, 1'b1, 0, 1'b0);
    check("t2_hitcnt", hit_count, 32'd1);

    // Long arbiter stall, then read timeout, then CLEAR at top address
    run_cmd(2'd0, 19'h00010, 36'h8, 20, 3, 1'b1, 0, 1'b0);
    run_cmd(2'd1, 19'h00020, 36'h1, 1, 3, 1'b0, 0, 1'b0);
    run_cmd(2'd2, 19'h7FFFF, 36'hF_FFFF_FFFF, 0, 3, 1'b1, 2, 1'b0);

    // enable low gates acceptance
    enable = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 19'h1; cmd_mask = 36'h1;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #2;
      if (cmd_ready || rd_req || wr_req) bad++;
    end
    check("enable_gate", bad, 0);
    cmd_valid = 1'b0; enable = 1'b1;
    @(posedge clk); #2;

    // Reset during RD_WAIT, then a late rd_vld must be ignored
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 19'h00123; cmd_mask = 36'h1;
    @(posedge clk); #1; cmd_valid = 1'b0; #1;
    check("mid_rd_req", rd_req, 1'b1);
    rd_ack = 1'b1;
    @(posedge clk); #1; rd_ack = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; #1;
    check_reset_outs("midrst");
    set_exp = '0; hit_exp = '0;
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1; rd_vld = 1'b1; rd_data = '1;
    @(posedge clk); #1; rd_vld = 1'b0; #1;
    check("late_vld_ignored", {result_vld, rd_req, wr_req, cmd_ready}, 4'b0001);
    run_cmd(2'd1, 19'h00123, 36'h30, 0, 3, 1'b1, 1, 1'b0);

    // Randomized traffic over a small address pool
    pool[0] = 19'h00010; pool[1] = 19'h7FFFF; pool[2] = 19'h00000;
    pool[3] = AW'($urandom());
    for (int i = 0; i < 40; i++) begin
      a = pool[$urandom_range(3, 0)];
      touch(a);
      case ($urandom_range(2, 0))
        0:       m = rand_word() & rand_word() & rand_word();
        1:       m = mem[a] & rand_word();
        default: m = DW'(1) << $urandom_range(DW - 1, 0);
      endcase
      run_cmd(2'($urandom_range(3, 0)), a, m, $urandom_range(4, 0),
              $urandom_range(6, 1), ($urandom_range(9, 0) != 0),
              $urandom_range(3, 0), ($urandom_range(3, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
